// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and squash handling.
// A load in EX whose destination (rt) is read by the ID-stage instruction
// inserts a one-cycle bubble and holds PC and IF/ID. A flush squashes the
// ID-stage instruction and takes priority over the stall.
// Optional bubble statistics counter: define ID_EX_BUBBLE_STATS_EN.
module id_ex_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // decoder control bits
  input  logic               i_jump,
  input  logic               i_branch,
  input  logic               i_regDst,
  input  logic               i_mem2Reg,
  input  logic               i_regWrite,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_sign_flag,
  input  logic               i_immediate,
  input  logic [1:0]         i_aluSrc,
  input  logic [1:0]         i_aluOp,
  input  logic [1:0]         i_width,
  // operands
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic               i_flush,
  input  logic               i_valid,
  // EX-stage registered copies
  output logic               o_ex_jump,
  output logic               o_ex_branch,
  output logic               o_ex_regDst,
  output logic               o_ex_mem2Reg,
  output logic               o_ex_regWrite,
  output logic               o_ex_memRead,
  output logic               o_ex_memWrite,
  output logic               o_ex_sign_flag,
  output logic               o_ex_immediate,
  output logic [1:0]         o_ex_aluSrc,
  output logic [1:0]         o_ex_aluOp,
  output logic [1:0]         o_ex_width,
  output logic [NB_DATA-1:0] o_ex_rs_data,
  output logic [NB_DATA-1:0] o_ex_rt_data,
  output logic [NB_DATA-1:0] o_ex_imm,
  output logic [NB_DATA-1:0] o_ex_pc4,
  output logic [NB_REG-1:0]  o_ex_rs,
  output logic [NB_REG-1:0]  o_ex_rt,
  output logic [NB_REG-1:0]  o_ex_rd,
  output logic               o_ex_valid,
  // hazard control
  output logic               o_pc_write,
  output logic               o_ifid_write,
  output logic               o_stall,
  output logic [NB_CNT-1:0]  o_bubble_cnt
);

  logic rt_used;
  logic rt_match;
  logic rs_match;
  logic hazard;
  logic bubble;

  // Hazard detection against the instruction currently held in EX.
  always_comb begin
    rt_used  = ~i_immediate | i_memWrite | i_branch;
    rs_match = (o_ex_rt == i_rs);
    rt_match = rt_used & (o_ex_rt == i_rt);
    hazard   = o_ex_valid & o_ex_memRead & (o_ex_rt != '0) & (rs_match | rt_match) & i_valid;
    // Reset wins: the reset cycle never holds the front end.
    o_stall      = hazard & ~i_flush & ~i_rst;
    o_pc_write   = ~o_stall;
    o_ifid_write = ~o_stall;
    bubble       = o_stall | i_flush | ~i_valid;
  end

  // Pipeline register: operands always load; control is zeroed on a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ex_jump      <= 1'b0;
      o_ex_branch    <= 1'b0;
      o_ex_regDst    <= 1'b0;
      o_ex_mem2Reg   <= 1'b0;
      o_ex_regWrite  <= 1'b0;
      o_ex_memRead   <= 1'b0;
      o_ex_memWrite  <= 1'b0;
      o_ex_sign_flag <= 1'b0;
      o_ex_immediate <= 1'b0;
      o_ex_aluSrc    <= 2'b00;
      o_ex_aluOp     <= 2'b00;
      o_ex_width     <= 2'b11;
      o_ex_rs_data   <= '0;
      o_ex_rt_data   <= '0;
      o_ex_imm       <= '0;
      o_ex_pc4       <= '0;
      o_ex_rs        <= '0;
      o_ex_rt        <= '0;
      o_ex_rd        <= '0;
      o_ex_valid     <= 1'b0;
    end else begin
      o_ex_regDst    <= i_regDst;
      o_ex_mem2Reg   <= i_mem2Reg;
      o_ex_sign_flag <= i_sign_flag;
      o_ex_immediate <= i_immediate;
      o_ex_aluSrc    <= i_aluSrc;
      o_ex_rs_data   <= i_rs_data;
      o_ex_rt_data   <= i_rt_data;
      o_ex_imm       <= i_imm;
      o_ex_pc4       <= i_pc4;
      o_ex_rs        <= i_rs;
      o_ex_rt        <= i_rt;
      o_ex_rd        <= i_rd;
      if (bubble) begin
        o_ex_jump     <= 1'b0;
        o_ex_branch   <= 1'b0;
        o_ex_regWrite <= 1'b0;
        o_ex_memRead  <= 1'b0;
        o_ex_memWrite <= 1'b0;
        o_ex_aluOp    <= 2'b00;
        o_ex_width    <= 2'b11;
        o_ex_valid    <= 1'b0;
      end else begin
        o_ex_jump     <= i_jump;
        o_ex_branch   <= i_branch;
        o_ex_regWrite <= i_regWrite;
        o_ex_memRead  <= i_memRead;
        o_ex_memWrite <= i_memWrite;
        o_ex_aluOp    <= i_aluOp;
        o_ex_width    <= i_width;
        o_ex_valid    <= i_valid;
      end
    end
  end

`ifdef ID_EX_BUBBLE_STATS_EN
  logic [NB_CNT-1:0] bubble_cnt_q;

  // Saturating count of stall and flush bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
    end else if ((o_stall | i_flush) && (bubble_cnt_q != {NB_CNT{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
`else
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes expected hazard outputs and
// expected EX contents; a monitor pops and compares each cycle.
module tb_id_ex_stage;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
  localparam int unsigned NB_CNT  = 16;

  typedef struct packed {
    logic jump, branch, regDst, mem2Reg, regWrite, memRead, memWrite, sign_flag, immediate;
    logic [1:0] aluSrc, aluOp, width;
    logic [NB_DATA-1:0] rs_data, rt_data, imm, pc4;
    logic [NB_REG-1:0] rs, rt, rd;
    logic valid;
  } ex_t;

  typedef struct packed {
    ex_t ex;
    logic full;
    logic [NB_CNT-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic stall;
  } stall_t;

  logic i_clk = 1'b0;
  logic i_rst, i_flush, i_valid;
  ex_t  din;
  ex_t  dout;
  logic o_pc_write, o_ifid_write, o_stall;
  logic [NB_CNT-1:0] o_bubble_cnt;

  int checks = 0;
  int errors = 0;

  exp_t   ex_q[$];
  stall_t st_q[$];

  // Reference state
  ex_t m_ex;
  logic [NB_CNT-1:0] m_cnt;

  always #5 i_clk = ~i_clk;

  id_ex_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_jump(din.jump), .i_branch(din.branch), .i_regDst(din.regDst), .i_mem2Reg(din.mem2Reg),
    .i_regWrite(din.regWrite), .i_memRead(din.memRead), .i_memWrite(din.memWrite),
    .i_sign_flag(din.sign_flag), .i_immediate(din.immediate),
    .i_aluSrc(din.aluSrc), .i_aluOp(din.aluOp), .i_width(din.width),
    .i_rs_data(din.rs_data), .i_rt_data(din.rt_data), .i_imm(din.imm), .i_pc4(din.pc4),
    .i_rs(din.rs), .i_rt(din.rt), .i_rd(din.rd),
    .i_flush(i_flush), .i_valid(i_valid),
    .o_ex_jump(dout.jump), .o_ex_branch(dout.branch), .o_ex_regDst(dout.regDst),
    .o_ex_mem2Reg(dout.mem2Reg), .o_ex_regWrite(dout.regWrite), .o_ex_memRead(dout.memRead),
    .o_ex_memWrite(dout.memWrite), .o_ex_sign_flag(dout.sign_flag),
    .o_ex_immediate(dout.immediate), .o_ex_aluSrc(dout.aluSrc), .o_ex_aluOp(dout.aluOp),
    .o_ex_width(dout.width), .o_ex_rs_data(dout.rs_data), .o_ex_rt_data(dout.rt_data),
    .o_ex_imm(dout.imm), .o_ex_pc4(dout.pc4), .o_ex_rs(dout.rs), .o_ex_rt(dout.rt),
    .o_ex_rd(dout.rd), .o_ex_valid(dout.valid),
    .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_stall(o_stall),
    .o_bubble_cnt(o_bubble_cnt)
  );

  function automatic logic [NB_REG-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd9;
      2: return 5'd4;
      default: return NB_REG'($urandom_range(0, 31));
    endcase
  endfunction

  // Drive one cycle of stimulus and push the expected responses.
  task automatic step(input logic rst, input logic flush, input logic valid,
                      input logic mem_read, input logic imm_flag, input logic mem_write,
                      input logic branch, input logic reg_write,
                      input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt);
    ex_t    d;
    exp_t   e;
    stall_t s;
    logic   load_use, stall;
    @(negedge i_clk);
    d = ex_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    d.memRead   = mem_read;
    d.immediate = imm_flag;
    d.memWrite  = mem_write;
    d.branch    = branch;
    d.regWrite  = reg_write;
    d.rs        = rs;
    d.rt        = rt;
    d.valid     = valid;
    din     = d;
    i_rst   = rst;
    i_flush = flush;
    i_valid = valid;

    // A load in EX blocks a reader of its destination; r0 is never a dependency.
    load_use = m_ex.valid && m_ex.memRead && (m_ex.rt != 0) &&
               ((m_ex.rt == rs) || ((!imm_flag || mem_write || branch) && (m_ex.rt == rt)));
    stall = load_use && valid && !flush && !rst;
    s.stall = stall;
    st_q.push_back(s);

    if (rst) begin
      m_ex = '0;
      m_ex.width = 2'b11;
      m_cnt = '0;
      e.full = 1'b1;
    end else begin
`ifdef ID_EX_BUBBLE_STATS_EN
      if ((stall || flush) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      m_ex = d;
      if (stall || flush || !valid) begin
        m_ex.jump = 0; m_ex.branch = 0; m_ex.regWrite = 0; m_ex.memRead = 0;
        m_ex.memWrite = 0; m_ex.valid = 0; m_ex.aluOp = 2'b00; m_ex.width = 2'b11;
        e.full = 1'b0;
      end else begin
        e.full = 1'b1;
      end
    end
    e.ex  = m_ex;
    e.cnt = m_cnt;
    ex_q.push_back(e);
  endtask

  task automatic rnd_step(input logic flush_bias);
    logic rst, flush;
    rst   = ($urandom_range(0, 49) == 0);
    flush = flush_bias | ($urandom_range(0, 9) == 0);
    step(rst, flush, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
         $urandom_range(0, 1) == 1, pick_reg(), pick_reg());
  endtask

  // Monitor: hazard outputs mid-cycle, EX registers just after each edge.
  initial begin
    stall_t s;
    exp_t   e;
    ex_t    a, x;
    forever begin
      @(negedge i_clk);
      #2;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        checks++;
        if (o_stall !== s.stall || o_pc_write !== ~s.stall || o_ifid_write !== ~s.stall) begin
          errors++;
          $display("FAIL stall: stall=%0b pc_write=%0b ifid_write=%0b required stall=%0b",
                   o_stall, o_pc_write, o_ifid_write, s.stall);
        end
      end
      @(posedge i_clk);
      #1;
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        a = dout;
        x = e.ex;
        if (!e.full) begin
          // Operand fields are don't-care in a bubble.
          a.regDst = 0; a.mem2Reg = 0; a.sign_flag = 0; a.immediate = 0; a.aluSrc = 0;
          a.rs_data = 0; a.rt_data = 0; a.imm = 0; a.pc4 = 0; a.rs = 0; a.rt = 0; a.rd = 0;
          x.regDst = 0; x.mem2Reg = 0; x.sign_flag = 0; x.immediate = 0; x.aluSrc = 0;
          x.rs_data = 0; x.rt_data = 0; x.imm = 0; x.pc4 = 0; x.rs = 0; x.rt = 0; x.rd = 0;
        end
        checks++;
        if (a !== x) begin
          errors++;
          $display("FAIL ex_regs: got %h required %h", a, x);
        end
        checks++;
        if (o_bubble_cnt !== e.cnt) begin
          errors++;
          $display("FAIL bubble_cnt: got %0d required %0d", o_bubble_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    m_ex = '0;
    m_cnt = '0;
    din = '0;
    i_rst = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    // Reset, then lw $t1 followed by dependent add: one bubble, then add enters EX.
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(0, 0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd10);
    step(0, 0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd10);
    // addi rt=9 does not read rt; sw rt=9 does.
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(0, 0, 1, 0, 1, 0, 0, 1, 5'd4, 5'd9);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(0, 0, 1, 0, 1, 1, 0, 0, 5'd4, 5'd9);
    step(0, 0, 1, 0, 1, 1, 0, 0, 5'd4, 5'd9);
    // Load to r0 never stalls.
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd0);
    step(0, 0, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0);
    // Hazard coinciding with flush.
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(0, 1, 1, 0, 0, 0, 0, 1, 5'd9, 5'd9);
    // Back-to-back dependent loads.
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd9, 5'd7);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd9, 5'd7);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd7, 5'd3);
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd7, 5'd3);
    // Reset during a stall.
    step(0, 0, 1, 1, 1, 0, 0, 1, 5'd2, 5'd9);
    step(1, 0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd9);
    step(0, 0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd9);
    for (int i = 0; i < 3000; i++) rnd_step(1'b0);
    // Saturation: more than 2^16 consecutive flushes after a clean reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    for (int i = 0; i < 65540; i++) begin
      step(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0, 0, 1,
           pick_reg(), pick_reg());
    end
    for (int i = 0; i < 20; i++) rnd_step(1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    #3;
    checks++;
    if (ex_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending ex=%0d stall=%0d required 0", ex_q.size(), st_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: NB_DATA, 32, datapath width; NB_REG, 5, register-index width; NB_CNT, 16, bubble-counter width.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous reset, active-high.
REQ-004 i_jump, i_branch, i_regDst, i_mem2Reg, i_regWrite, i_memRead, i_memWrite, i_sign_flag, i_immediate  in  1 each  decoder control bits for the ID-stage instruction.
REQ-005 i_aluSrc, i_aluOp, i_width  in  2 each  decoder control fields.
REQ-006 i_rs_data, i_rt_data, i_imm, i_pc4  in  NB_DATA each  register-file read data, extended immediate, PC+4.
REQ-007 i_rs, i_rt, i_rd  in  NB_REG each  register indices of the ID-stage instruction.
REQ-008 i_flush  in  1  control-transfer taken; squash the ID-stage instruction.
REQ-009 i_valid  in  1  ID-stage holds a real instruction.
REQ-010 o_* (ex_ prefix) out  same widths  registered copies of every REQ-004..007 input, plus o_ex_valid (1).
REQ-011 o_pc_write, o_ifid_write  out  1 each  hold PC and IF/ID when 0.
REQ-012 o_stall  out  1  load-use bubble inserted this cycle.
REQ-013 o_bubble_cnt  out  NB_CNT  bubble statistics counter.

Function
REQ-014 rt_used = ~i_immediate | i_memWrite | i_branch; rs always used.
REQ-015 Load-use hazard = o_ex_valid & o_ex_memRead & (o_ex_rt != 0) & ((o_ex_rt == i_rs) | (rt_used & o_ex_rt == i_rt)) & i_valid; combinational.
REQ-016 o_stall = hazard & ~i_flush; o_pc_write = o_ifid_write = ~o_stall.
REQ-017 Normal cycle (no hazard, no flush): all ex_ registers load inputs next edge; o_ex_valid <= i_valid; latency 1 cycle.
REQ-018 Bubble (o_stall or i_flush or ~i_valid): control bits regWrite, memRead, memWrite, branch, jump, ex_valid load 0; data/index registers load inputs (don't-care).
REQ-019 Flush has priority over stall; flush never asserts o_stall and releases PC/IF-ID hold.
REQ-020 Stall lasts exactly one cycle per hazard: after the bubble o_ex_memRead = 0, so hazard clears unless new load enters EX.
REQ-021 Back-to-back loads with dependency: each dependent pair generates one bubble; no deadlock.
REQ-022 o_ex_width bubble value 2'b11; o_ex_aluOp bubble value 2'b00.
REQ-023 Index 0 never produces a hazard.

Reset
REQ-024 On i_rst at rising edge: all ex_ outputs 0 except o_ex_width = 2'b11; o_bubble_cnt = 0.
REQ-025 Reset overrides stall and flush; o_stall, o_pc_write, o_ifid_write follow REQ-016 from reset register values (no hazard, so pc_write = 1) in the reset cycle and after.
REQ-026 Reset mid-stall: bubble discarded, first post-reset cycle normal.

Configuration
REQ-027 Macro ID_EX_BUBBLE_STATS_EN defined: o_bubble_cnt increments by 1 on each edge where o_stall or i_flush is 1 (i_rst low), saturating at all-ones.
REQ-028 Macro undefined: counter logic absent; o_bubble_cnt constant 0; all other behaviour identical.

Verification
REQ-029 lw $t1 (EX, memRead=1, ex_rt=9) then ID add rs=9 -> o_stall=1, pc_write=0 one cycle; next cycle ex_regWrite=0, ex_valid=0; following cycle add enters EX with regWrite=1.
REQ-030 lw ex_rt=9, ID addi rt=9 rs=4 (immediate=1) -> no stall; sw rt=9 rs=4 -> stall.
REQ-031 lw ex_rt=0, ID rs=0 -> no stall.
REQ-032 Hazard and i_flush same cycle -> o_stall=0, pc_write=1, next EX bubble; counter +1 (macro on).
REQ-033 i_rst high during stall -> next edge all ex_ outputs 0, width=2'b11, bubble_cnt=0.
REQ-034 Macro on, force 65536 consecutive flush cycles -> o_bubble_cnt holds 16'hFFFF; macro off -> stays 0.
